// File: rtl/fifo_reader.sv
// Read-side engine for the fifo block: polls the FIFO, stages returned words,
// packs RATIO of them into one wide word and presents it on a valid/ready stream.
module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          flush,
   output logic                          fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
   input  logic                          fifo_rd_val,
   output logic [DATA_WIDTH*RATIO-1:0]   m_data,
   output logic [$clog2(RATIO+1)-1:0]    m_words,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          idle
);

   localparam int CW = $clog2(RATIO+1);
   localparam int OW = $clog2(BUF_DEPTH+1);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int WW = DATA_WIDTH*RATIO;
   localparam logic [OW:0] DEPTH_L = (OW+1)'(BUF_DEPTH);

   logic                  enable_q;
   logic                  inflight_q;
   logic [OW-1:0]         occ_q, occ_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
   logic [WW-1:0]         pack_q, pack_d;
   logic [CW-1:0]         pack_cnt_q, pack_cnt_d;
   logic [WW-1:0]         m_data_q, m_data_d;
   logic [CW-1:0]         m_words_q, m_words_d;
   logic                  m_valid_q, m_valid_d;

   logic [OW:0]           demand_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  out_free_s;
   logic                  last_slot_s;
   logic                  flush_go_s;
   logic [DATA_WIDTH-1:0] head_s;
   logic [WW-1:0]         pack_merge_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(BUF_DEPTH-1)) begin
         ptr_inc = {PW{1'b0}};
      end else begin
         ptr_inc = p + PW'(1);
      end
   endfunction

   // Request throttle, staging push/pop decisions, pack and output next state.
   always_comb begin
      demand_s    = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
      fifo_rd_en  = enable_q & (demand_s < DEPTH_L);
      push_s      = inflight_q & fifo_rd_val;
      head_s      = buf_q[rd_ptr_q];
      out_free_s  = ~m_valid_q | m_ready;
      last_slot_s = (pack_cnt_q == CW'(RATIO-1));
      pop_s       = (occ_q != {OW{1'b0}}) & (~last_slot_s | out_free_s);
      // A partial word only leaves once nothing more can join it.
      flush_go_s  = flush & (pack_cnt_q != {CW{1'b0}}) & (occ_q == {OW{1'b0}})
                    & ~inflight_q & out_free_s;

      pack_merge_s = pack_q;
      for (int i = 0; i < RATIO; i++) begin
         if (pack_cnt_q == CW'(i)) begin
            pack_merge_s[i*DATA_WIDTH +: DATA_WIDTH] = head_s;
         end else begin
            pack_merge_s[i*DATA_WIDTH +: DATA_WIDTH] = pack_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      pack_d     = pack_q;
      pack_cnt_d = pack_cnt_q;
      m_data_d   = m_data_q;
      m_words_d  = m_words_q;
      m_valid_d  = m_valid_q & ~m_ready;
      if (pop_s) begin
         if (last_slot_s) begin
            m_data_d   = pack_merge_s;
            m_words_d  = CW'(RATIO);
            m_valid_d  = 1'b1;
            pack_d     = {WW{1'b0}};
            pack_cnt_d = {CW{1'b0}};
         end else begin
            pack_d     = pack_merge_s;
            pack_cnt_d = pack_cnt_q + CW'(1);
         end
      end else if (flush_go_s) begin
         m_data_d   = pack_q;
         m_words_d  = pack_cnt_q;
         m_valid_d  = 1'b1;
         pack_d     = {WW{1'b0}};
         pack_cnt_d = {CW{1'b0}};
      end else begin
         pack_d = pack_q;
      end

      wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q   <= 1'b0;
         inflight_q <= 1'b0;
         occ_q      <= {OW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_q[i] <= {DATA_WIDTH{1'b0}};
         end
         pack_q     <= {WW{1'b0}};
         pack_cnt_q <= {CW{1'b0}};
         m_data_q   <= {WW{1'b0}};
         m_words_q  <= {CW{1'b0}};
         m_valid_q  <= 1'b0;
      end else begin
         enable_q   <= enable;
         inflight_q <= fifo_rd_en;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (push_s) begin
            buf_q[wr_ptr_q] <= fifo_rd_data;
         end else begin
            buf_q[wr_ptr_q] <= buf_q[wr_ptr_q];
         end
         pack_q     <= pack_d;
         pack_cnt_q <= pack_cnt_d;
         m_data_q   <= m_data_d;
         m_words_q  <= m_words_d;
         m_valid_q  <= m_valid_d;
      end
   end

   assign m_data  = m_data_q;
   assign m_words = m_words_q;
   assign m_valid = m_valid_q;
   assign idle    = ~inflight_q & (occ_q == {OW{1'b0}}) & (pack_cnt_q == {CW{1'b0}}) & ~m_valid_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised bench for fifo_reader: the bench plays the FIFO and checks the packed
// stream against a queue of the words it handed out.
module tb_fifo_reader;

   localparam int DW = 8;
   localparam int R  = 4;
   localparam int BD = 4;

   logic clk, reset;
   logic enable, flush, rd_val, m_ready, rd_en, m_valid, idle;
   logic [DW-1:0]   rd_data;
   logic [DW*R-1:0] m_data;
   logic [2:0]      m_words;

   logic enable1, rd_val1, rd_en1, m_valid1, idle1;
   logic [DW-1:0] rd_data1, m_data1;
   logic [0:0]    m_words1;

   fifo_reader #(.DATA_WIDTH(DW), .RATIO(R), .BUF_DEPTH(BD)) dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .fifo_rd_en(rd_en), .fifo_rd_data(rd_data), .fifo_rd_val(rd_val),
      .m_data(m_data), .m_words(m_words), .m_valid(m_valid), .m_ready(m_ready), .idle(idle));

   fifo_reader #(.DATA_WIDTH(DW), .RATIO(1), .BUF_DEPTH(3)) dut1 (
      .clk(clk), .reset(reset), .enable(enable1), .flush(1'b0),
      .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1), .fifo_rd_val(rd_val1),
      .m_data(m_data1), .m_words(m_words1), .m_valid(m_valid1), .m_ready(1'b1), .idle(idle1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] fifo1_q[$];
   logic [31:0]   acc_log[$];
   int            acc_words[$];
   int            flush_n = 0;
   bit            rd_en_prev = 1'b0;
   bit            en_last = 1'b0;
   bit            inject = 1'b0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            cmp_n;
   logic [31:0]   cmp_ed;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Per-cycle compare of the R=4 instance against the handed-out word queue.
   always @(negedge clk) begin
      if (!reset) begin
         rd_en_prev = 1'b0;
         en_last    = 1'b0;
      end else begin
         check("idle", 64'(idle), 64'(exp_q.size() == 0 && !rd_en_prev));
         if (!en_last) check("rd_en_disabled", 64'(rd_en), 64'd0);
         else if (exp_q.size() == 0) check("rd_en_poll", 64'(rd_en), 64'd1);
         check("hold_bound", 64'(exp_q.size() <= BD + 2*R - 1), 64'd1);
         if (m_valid) begin
            cmp_n = (flush_n > 0) ? flush_n : ((exp_q.size() >= R) ? R : 0);
            if (cmp_n == 0 || exp_q.size() < cmp_n) begin
               n_checks++;
               n_errors++;
               $display("FAIL out_spurious: m_valid=1 with %0d pending words, required m_valid=0", exp_q.size());
            end else begin
               cmp_ed = 32'd0;
               for (int i = 0; i < cmp_n; i++) cmp_ed[i*DW +: DW] = exp_q[i];
               check("m_data", 64'(m_data), 64'(cmp_ed));
               check("m_words", 64'(m_words), 64'(cmp_n));
               if (m_ready) begin
                  for (int i = 0; i < cmp_n; i++) void'(exp_q.pop_front());
                  acc_log.push_back(m_data);
                  acc_words.push_back(int'(m_words));
                  flush_n = 0;
               end
            end
         end
         rd_en_prev = rd_en;
         en_last    = enable;
      end
   end

   // One cycle: advance past the edge, then answer last cycle's request as the FIFO.
   task automatic step();
      @(posedge clk);
      #2;
      if (rd_en_prev) begin
         if (fifo_q.size() > 0) begin
            rd_val  = 1'b1;
            rd_data = fifo_q.pop_front();
            exp_q.push_back(rd_data);
         end else begin
            rd_val  = 1'b0;
            rd_data = 8'(DW'($urandom));
         end
      end else if (inject && $urandom_range(0, 19) == 0) begin
         rd_val  = 1'b1;
         rd_data = 8'(DW'($urandom));
      end else begin
         rd_val = 1'b0;
      end
   endtask

   task automatic flush_pulse();
      flush   = 1'b1;
      flush_n = (exp_q.size() < R) ? exp_q.size() : 0;
      step();
      flush = 1'b0;
   endtask

   task automatic push_words(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
   endtask

   int cnt;
   int first_val, first_v, last_v, nout;
   bit en1_prev;

   initial begin
      reset = 1'b0; enable = 1'b0; flush = 1'b0; rd_val = 1'b0; m_ready = 1'b0;
      rd_data = 8'h00; enable1 = 1'b0; rd_val1 = 1'b0; rd_data1 = 8'h00;
      #1;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_m_words", 64'(m_words), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      repeat (3) step();
      reset = 1'b1;

      // Preloaded 0x11..0x18, free-running downstream.
      push_words(8'h11, 8);
      enable = 1'b1; m_ready = 1'b1;
      step();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rd_en) cnt++;
      end
      repeat (6) step();
      check("t1_rd_en_cycles", 64'(cnt), 64'd10);
      check("t1_count", 64'(acc_log.size()), 64'd2);
      if (acc_log.size() >= 2) begin
         check("t1_word0", 64'(acc_log[0]), 64'h14131211);
         check("t1_word1", 64'(acc_log[1]), 64'h18171615);
         check("t1_words", 64'(acc_words[1]), 64'd4);
      end

      // Empty FIFO polling: the compare process covers rd_en/idle each cycle.
      repeat (10) step();
      check("t2_no_output", 64'(acc_log.size()), 64'd2);

      // Stall with 12 words queued.
      m_ready = 1'b0;
      push_words(8'h11, 12);
      repeat (20) step();
      check("t3_captured", 64'(exp_q.size()), 64'd11);
      check("t3_left_in_fifo", 64'(fifo_q.size()), 64'd1);
      check("t3_rd_en_stopped", 64'(rd_en), 64'd0);
      check("t3_held_valid", 64'(m_valid), 64'd1);
      check("t3_held_data", 64'(m_data), 64'h14131211);
      acc_log.delete(); acc_words.delete();
      m_ready = 1'b1;
      repeat (20) step();
      check("t3_release_count", 64'(acc_log.size()), 64'd3);
      if (acc_log.size() >= 3) begin
         check("t3_out0", 64'(acc_log[0]), 64'h14131211);
         check("t3_out1", 64'(acc_log[1]), 64'h18171615);
         check("t3_out2", 64'(acc_log[2]), 64'h1C1B1A19);
      end

      // Partial word and flush.
      acc_log.delete(); acc_words.delete();
      push_words(8'hA1, 3);
      repeat (10) step();
      enable = 1'b0;
      repeat (3) step();
      flush_pulse();
      repeat (4) step();
      check("t4_flush_count", 64'(acc_log.size()), 64'd1);
      if (acc_log.size() >= 1) begin
         check("t4_flush_data", 64'(acc_log[0]), 64'h00A3A2A1);
         check("t4_flush_words", 64'(acc_words[0]), 64'd3);
      end
      flush_pulse();
      repeat (4) step();
      check("t4_empty_flush", 64'(acc_log.size()), 64'd1);
      check("t4_empty_valid", 64'(m_valid), 64'd0);

      // Reset in the middle of packing.
      enable = 1'b1; m_ready = 1'b0;
      push_words(8'h21, 6);
      repeat (15) step();
      check("t5_pre_valid", 64'(m_valid), 64'd1);
      check("t5_pre_captured", 64'(exp_q.size()), 64'd6);
      reset = 1'b0;
      fifo_q.delete(); exp_q.delete(); flush_n = 0; rd_val = 1'b0;
      #1;
      check("t5_rst_valid", 64'(m_valid), 64'd0);
      check("t5_rst_idle", 64'(idle), 64'd1);
      check("t5_rst_data", 64'(m_data), 64'd0);
      check("t5_rst_words", 64'(m_words), 64'd0);
      check("t5_rst_rd_en", 64'(rd_en), 64'd0);
      repeat (2) step();
      reset = 1'b1;
      m_ready = 1'b1;
      acc_log.delete(); acc_words.delete();
      push_words(8'h31, 4);
      repeat (12) step();
      check("t5_after_count", 64'(acc_log.size()), 64'd1);
      if (acc_log.size() >= 1) check("t5_after_data", 64'(acc_log[0]), 64'h34333231);

      // Randomised traffic with periodic drain and flush.
      inject = 1'b1;
      for (int blk = 0; blk < 8; blk++) begin
         for (int c = 0; c < 150; c++) begin
            step();
            if ($urandom_range(0, 99) < 40) begin
               for (int k = $urandom_range(1, 3); k > 0; k--) fifo_q.push_back(8'(DW'($urandom)));
            end
            enable  = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 9) < 6);
         end
         enable = 1'b0; m_ready = 1'b1;
         repeat (15) step();
         flush_pulse();
         repeat (4) step();
         check("rand_drained", 64'(exp_q.size()), 64'd0);
      end
      inject = 1'b0;
      rd_val = 1'b0;

      // RATIO=1, BUF_DEPTH=3 burst on the second instance.
      for (int i = 0; i < 16; i++) fifo1_q.push_back(8'h60 + 8'(i));
      first_val = -1; first_v = -1; last_v = -1; nout = 0; en1_prev = 1'b0;
      enable1 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #2;
         if (en1_prev && fifo1_q.size() > 0) begin
            rd_val1  = 1'b1;
            rd_data1 = fifo1_q.pop_front();
            if (first_val < 0) first_val = c;
         end else begin
            rd_val1 = 1'b0;
         end
         @(negedge clk);
         en1_prev = rd_en1;
         if (m_valid1) begin
            check("r1_data", 64'(m_data1), 64'(8'h60 + 8'(nout)));
            check("r1_words", 64'(m_words1), 64'd1);
            if (first_v < 0) first_v = c;
            last_v = c;
            nout++;
         end
      end
      enable1 = 1'b0;
      check("r1_latency", 64'(first_v - first_val), 64'd2);
      check("r1_count", 64'(nout), 64'd16);
      check("r1_back_to_back", 64'(last_v - first_v), 64'd15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
